// File: rtl/clt_gauss.sv
// clt_gauss: central-limit normal sample generator.
// Sums NSUM consecutive accepted uniform samples (the top UBITS bits of each
// 32-bit word) and removes the mean. The result is a signed fixed-point
// sample that is approximately normally distributed.
// Optional feature macro: CLT_DISCARD_ON_ERROR_EN. When it is defined, an
// accept flagged in_error drops the partial sum instead of summing the sample.
module clt_gauss #(
  parameter int DELAY = 1,
  parameter int NSUM  = 12,
  parameter int UBITS = 16,
  parameter int OW    = 21
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  input  logic                 in_error,
  output logic                 in_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 error,
  output logic [3:0]           count
);

  // The accumulator holds at most NSUM*(2^UBITS-1), and that fits in UBITS+4 bits.
  localparam int            AW     = UBITS + 4;
  localparam logic [3:0]    LAST   = 4'(NSUM - 1);
  localparam logic [OW-1:0] OFFSET = OW'(NSUM * (2 ** (UBITS - 1)));

  // Reject parameter sets whose arithmetic widths would not hold.
  // DELAY exists only for simulation models. This RTL does not use it.
  if (NSUM < 2 || NSUM > 16 || OW != UBITS + 5 || DELAY < 0) begin : g_param_chk
    $error("clt_gauss: illegal parameter combination");
  end

  logic [AW-1:0]    r_acc;
  logic [3:0]       r_count;
  logic             r_out_valid;
  logic [OW-1:0]    r_out_data;
  logic             r_error;

  logic [UBITS-1:0] w_u;
  logic             w_last;
  logic             w_accept;
  logic             w_discard;
  logic             w_done;
  logic [AW-1:0]    w_sum;
  logic [OW-1:0]    w_res;

  assign w_u      = in_data[31 -: UBITS];
  assign w_last   = (r_count == LAST);
  // Block only the final sample of a sum, and only while the previous result
  // is still unclaimed. Earlier samples never need the output slot.
  assign in_ready = !w_last || !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef CLT_DISCARD_ON_ERROR_EN
  assign w_discard = w_accept && in_error;
`else
  assign w_discard = 1'b0;
`endif

  assign w_done = w_accept && w_last && !w_discard;
  assign w_sum  = r_acc + AW'(w_u);
  // Subtract the mean at full output width. The result wraps into two's complement.
  assign w_res  = OW'(w_sum) - OFFSET;

  // Update the accumulator, sample count, output slot and sticky error.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_error     <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_accept && in_error)     r_error     <= 1'b1;
      if (w_discard) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_done) begin
        // A completion overrides the drain. The slot refills in the same cycle.
        r_out_data  <= w_res;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_count     <= '0;
      end else if (w_accept) begin
        r_acc   <= w_sum;
        r_count <= r_count + 4'd1;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign error     = r_error;
  assign count     = r_count;

endmodule

// File: tb/tb_clt_gauss.sv
// tb_clt_gauss: bench for clt_gauss. A reference model tracks the partial sum
// as a plain integer and holds the pending result. Its behaviour is derived
// from the handshake and arithmetic rules.
module tb_clt_gauss;
  localparam int NSUM  = 12;
  localparam int UBITS = 16;
  localparam int OW    = 21;
  localparam int MEAN  = NSUM * (2 ** (UBITS - 1));

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b0;
  logic [31:0]          in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_error = 1'b0;
  logic                 in_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 error;
  logic [3:0]           count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int m_sum, m_count, m_out;
  bit m_ov, m_err;
  bit exp_rdy, obs_rdy;

  clt_gauss #(.DELAY(1), .NSUM(NSUM), .UBITS(UBITS), .OW(OW)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_data(in_data), .in_valid(in_valid), .in_error(in_error), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .error(error), .count(count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [OW-1:0] mexp();
    return OW'(m_out);
  endfunction

  // Drive one cycle and advance the model. The task returns 1 ns after the edge.
  task automatic drive(input bit v, input logic [31:0] d, input bit e, input bit r);
    bit acc;
    int u;
    in_valid = v; in_data = d; in_error = e; out_ready = r;
    #1;
    exp_rdy = (m_count != NSUM - 1) || !m_ov || r;
    obs_rdy = in_ready;
    acc = v && exp_rdy;
    @(posedge CLK);
    if (m_ov && r) m_ov = 1'b0;
    if (acc) begin
      u = int'(d[31:16]);
      if (e) m_err = 1'b1;
`ifdef CLT_DISCARD_ON_ERROR_EN
      if (e) begin
        m_sum = 0; m_count = 0;
      end else
`endif
      if (m_count == NSUM - 1) begin
        m_out = m_sum + u - MEAN; m_ov = 1'b1; m_sum = 0; m_count = 0;
      end else begin
        m_sum += u; m_count++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0; in_valid = 1'b0; in_error = 1'b0; out_ready = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    m_sum = 0; m_count = 0; m_out = 0; m_ov = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", error); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got=%b exp=1", in_ready); end
  endtask

  task automatic test_midscale();
    for (int i = 0; i < NSUM; i++) begin
      drive(1'b1, 32'h8000_1234, 1'b0, 1'b1);
      if (i < NSUM - 1) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_early_ov i=%0d got=%b exp=0", i, out_valid); end
      end
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_ov got=%b exp=1", out_valid); end
    n_cmp++; if (out_data !== 21'd0) begin n_bad++; $display("FAIL mid_data got=%h exp=0", out_data); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_ov_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < NSUM; i++) drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    n_cmp++; if (out_data !== 21'h05FFF4 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL max_data got=%h/%b exp=05fff4/1", out_data, out_valid); end
    for (int i = 0; i < NSUM; i++) drive(1'b1, 32'h0000_FFFF, 1'b0, 1'b1);
    n_cmp++; if (out_data !== 21'h1A0000 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL min_data got=%h/%b exp=1a0000/1", out_data, out_valid); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] held;
    for (int i = 0; i < NSUM; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    held = mexp();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin
      n_bad++; $display("FAIL bp_first got=%h/%b exp=%h/1", out_data, out_valid, held); end
    for (int i = 0; i < NSUM - 1; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    n_cmp++; if (count !== 4'd11) begin n_bad++; $display("FAIL bp_cnt got=%0d exp=11", count); end
    drive(1'b1, $urandom, 1'b0, 1'b0);
    n_cmp++; if (obs_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_rdy got=%b exp=0", obs_rdy); end
    n_cmp++; if (out_data !== held || count !== 4'd11) begin
      n_bad++; $display("FAIL bp_hold got=%h cnt=%0d exp=%h cnt=11", out_data, count, held); end
    drive(1'b1, $urandom, 1'b0, 1'b1);
    n_cmp++; if (obs_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_release got=%b exp=1", obs_rdy); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== mexp() || count !== 4'd0) begin
      n_bad++; $display("FAIL bp_new got=%h/%b cnt=%0d exp=%h/1 cnt=0", out_data, out_valid, count, mexp()); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'b0, 1'b1);
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL rm_cnt5 got=%0d exp=5", count); end
    do_reset();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rm_cnt0 got=%0d exp=0", count); end
    for (int i = 0; i < NSUM; i++) drive(1'b1, 32'h8000_0000, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 21'd0 || error !== 1'b0) begin
      n_bad++; $display("FAIL rm_out got=%h/%b err=%b exp=0/1 err=0", out_data, out_valid, error); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_error();
    int more;
    do_reset();
    drive(1'b1, $urandom, 1'b0, 1'b1);
    drive(1'b1, $urandom, 1'b0, 1'b1);
    drive(1'b1, $urandom, 1'b1, 1'b1);
`ifdef CLT_DISCARD_ON_ERROR_EN
    more = NSUM;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL err_cnt got=%0d exp=0", count); end
`else
    more = NSUM - 3;
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL err_cnt got=%0d exp=3", count); end
`endif
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b exp=1", error); end
    for (int i = 0; i < more - 1; i++) drive(1'b1, $urandom, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL err_early_ov got=%b exp=0", out_valid); end
    drive(1'b1, $urandom, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== mexp()) begin
      n_bad++; $display("FAIL err_out got=%h/%b exp=%h/1", out_data, out_valid, mexp()); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", error); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 97) == 0, ($urandom % 3) != 0);
      n_cmp++; if (obs_rdy !== exp_rdy) begin n_bad++; $display("FAIL rnd_rdy i=%0d got=%b exp=%b", i, obs_rdy, exp_rdy); end
      n_cmp++; if (out_valid !== m_ov || count !== 4'(m_count) || error !== m_err) begin
        n_bad++; $display("FAIL rnd_state i=%0d ov=%b cnt=%0d err=%b exp ov=%b cnt=%0d err=%b",
                          i, out_valid, count, error, m_ov, m_count, m_err); end
      if (m_ov) begin
        n_cmp++; if (out_data !== mexp()) begin n_bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, out_data, mexp()); end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_midscale();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_error();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
